// File: rtl/sw_sched_wh.sv
// rtl/sw_sched_wh.sv - wormhole switch scheduler: round-robin head arbitration, per-output packet lock, credit tracking
// Optional SW_SCHED_PERF_EN adds stall_cnt, a saturating per-output count of cycles with requests but no grant.
module sw_sched_wh #(
  parameter int PORT_NUM   = 5,
  parameter int CREDIT_MAX = 4,
  parameter int CW         = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [PORT_NUM-1:0]     req,
  input  logic [3*PORT_NUM-1:0]   route_sel,
  input  logic [PORT_NUM-1:0]     is_head,
  input  logic [PORT_NUM-1:0]     is_tail,
  input  logic [PORT_NUM-1:0]     credit_ret,
  output logic [PORT_NUM-1:0]     grant,
  output logic [3*PORT_NUM-1:0]   xbar_sel,
  output logic [PORT_NUM-1:0]     xbar_vld,
`ifdef SW_SCHED_PERF_EN
  output logic [16*PORT_NUM-1:0]  stall_cnt,
`endif
  output logic                    credit_err
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              state   [PORT_NUM];
  logic [2:0]          owner   [PORT_NUM];
  logic [2:0]          ptr     [PORT_NUM];
  logic [CW-1:0]       credit  [PORT_NUM];
  logic [PORT_NUM-1:0] hit     [PORT_NUM];
  logic [PORT_NUM-1:0] out_gnt [PORT_NUM];
  logic [2:0]          win     [PORT_NUM];
  logic [2:0]          idx;

  always_comb begin
    idx   = '0;
    grant = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      out_gnt[o] = '0;
      win[o]     = '0;
      for (int i = 0; i < PORT_NUM; i++)
        hit[o][i] = req[i] && (route_sel[3*i +: 3] == 3'(o));
      if (rst_n && credit[o] != '0) begin
        if (state[o] == LOCKED) begin
          if (hit[o][owner[o]]) begin
            out_gnt[o][owner[o]] = 1'b1;
            win[o]               = owner[o];
          end
        end else begin
          // Scan from farthest to nearest so the candidate closest after ptr is the last one kept.
          for (int k = PORT_NUM; k >= 1; k--) begin
            idx = 3'((int'(ptr[o]) + k) % PORT_NUM);
            if (hit[o][idx] && is_head[idx]) begin
              out_gnt[o]      = '0;
              out_gnt[o][idx] = 1'b1;
              win[o]          = idx;
            end
          end
        end
      end
      grant = grant | out_gnt[o];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < PORT_NUM; o++) begin
        state[o]  <= IDLE;
        owner[o]  <= '0;
        ptr[o]    <= 3'(PORT_NUM-1);
        credit[o] <= CW'(CREDIT_MAX);
      end
      xbar_sel   <= '0;
      xbar_vld   <= '0;
      credit_err <= 1'b0;
    end else begin
      for (int o = 0; o < PORT_NUM; o++) begin
        xbar_vld[o] <= |out_gnt[o];
        if (|out_gnt[o]) begin
          xbar_sel[3*o +: 3] <= win[o];
          if (state[o] == IDLE) begin
            ptr[o] <= win[o];
            if (!is_tail[win[o]]) begin
              state[o] <= LOCKED;
              owner[o] <= win[o];
            end
          end else if (is_tail[win[o]]) begin
            state[o] <= IDLE;
          end
        end
        if (credit_ret[o] && !(|out_gnt[o])) begin
          if (credit[o] == CW'(CREDIT_MAX))
            credit_err <= 1'b1;
          else
            credit[o] <= credit[o] + CW'(1);
        end else if (!credit_ret[o] && (|out_gnt[o])) begin
          credit[o] <= credit[o] - CW'(1);
        end
      end
    end
  end

`ifdef SW_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else begin
      for (int o = 0; o < PORT_NUM; o++)
        if ((|hit[o]) && !(|out_gnt[o]) && stall_cnt[16*o +: 16] != 16'hFFFF)
          stall_cnt[16*o +: 16] <= stall_cnt[16*o +: 16] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sw_sched_wh.sv
// tb/tb_sw_sched_wh.sv - scoreboard bench for sw_sched_wh
module tb_sw_sched_wh;
  localparam int N = 5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0, is_head = '0, is_tail = '0, credit_ret = '0;
  logic [3*N-1:0] route_sel = '0;
  logic [N-1:0]   grant, xbar_vld;
  logic [3*N-1:0] xbar_sel;
  logic           credit_err;
  int             n_checks = 0;
  int             n_pass = 0;

  typedef struct {
    logic [N-1:0]   vld;
    logic [3*N-1:0] sel;
  } xb_t;
  xb_t exp_q[$];

  sw_sched_wh #(.PORT_NUM(N), .CREDIT_MAX(4), .CW(3)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .route_sel(route_sel),
    .is_head(is_head), .is_tail(is_tail), .credit_ret(credit_ret),
    .grant(grant), .xbar_sel(xbar_sel), .xbar_vld(xbar_vld),
    .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clear_in();
    req = '0; is_head = '0; is_tail = '0; route_sel = '0; credit_ret = '0;
  endtask

  task automatic set_in(input int i, input int o, input bit h, input bit t);
    req[i] = 1'b1;
    route_sel[3*i +: 3] = 3'(o);
    is_head[i] = h;
    is_tail[i] = t;
  endtask

  // Called just after a negedge with inputs applied: checks grant, queues the crossbar expectation,
  // then checks the crossbar outputs just after the following posedge.
  task automatic step(input string tag, input logic [N-1:0] exp_grant);
    xb_t e;
    logic [3*N-1:0] mask;
    int o;
    #1;
    check({tag, " grant"}, grant, exp_grant);
    e.vld = '0;
    e.sel = '0;
    for (int i = 0; i < N; i++)
      if (exp_grant[i]) begin
        o = int'(route_sel[3*i +: 3]);
        e.vld[o] = 1'b1;
        e.sel[3*o +: 3] = 3'(i);
      end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, " xbar_vld"}, xbar_vld, e.vld);
    mask = '0;
    for (int k = 0; k < N; k++) if (e.vld[k]) mask[3*k +: 3] = 3'b111;
    if (e.vld != '0) check({tag, " xbar_sel"}, xbar_sel & mask, e.sel);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_in();
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int f;
    logic [N-1:0] g;

    // reset state
    do_reset();
    #1;
    check("rst grant", grant, 0);
    check("rst xbar_vld", xbar_vld, 0);
    check("rst xbar_sel", xbar_sel, 0);
    check("rst credit_err", credit_err, 0);

    // round-robin fairness on output 3
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      clear_in();
      for (int i = 0; i < 3; i++) set_in(i, 3, 1, 1);
      credit_ret[3] = 1'b1;
      g = '0;
      g[k % 3] = 1'b1;
      step("rr", g);
    end
    check("rr credit_err", credit_err, 0);

    // wormhole lock on output 2
    do_reset();
    @(negedge clk); clear_in(); set_in(1, 2, 1, 0); step("wh head", 5'b00010);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); clear_in();
      set_in(1, 2, 0, k == 2);
      set_in(0, 2, 1, 1);
      credit_ret[2] = 1'b1;
      step("wh body", 5'b00010);
    end
    @(negedge clk); clear_in(); set_in(0, 2, 1, 1); credit_ret[2] = 1'b1;
    step("wh next", 5'b00001);

    // credit exhaustion on output 0
    do_reset();
    f = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk); clear_in();
      set_in(4, 0, f == 0, f == 5);
      credit_ret[0] = (c == 6);
      g = (c < 4 || c == 7) ? 5'b10000 : 5'b00000;
      step("cx", g);
      if (g[4]) f++;
    end

    // simultaneous grant and return, then overflow
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); clear_in();
      set_in(0, 1, 1, 1);
      credit_ret[1] = (c == 2);
      step("cs", (c < 5) ? 5'b00001 : 5'b00000);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); clear_in(); credit_ret[1] = 1'b1;
      step("cs ret", 5'b00000);
    end
    check("cs err before", credit_err, 0);
    @(negedge clk); clear_in(); credit_ret[1] = 1'b1; step("cs over", 5'b00000);
    check("cs err set", credit_err, 1);
    @(negedge clk); clear_in(); set_in(0, 1, 1, 1); step("cs after", 5'b00001);
    check("cs err sticky", credit_err, 1);

    // async reset while output 2 is locked to input 3
    do_reset();
    @(negedge clk); clear_in(); set_in(3, 2, 1, 0); step("ar head", 5'b01000);
    @(negedge clk); clear_in(); set_in(3, 2, 0, 0); step("ar body", 5'b01000);
    @(negedge clk); clear_in(); set_in(3, 2, 0, 0);
    #1 check("ar locked grant", grant, 5'b01000);
    #1 rst_n = 1'b0;
    #1;
    check("ar rst grant", grant, 0);
    check("ar rst xbar_vld", xbar_vld, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_in(); set_in(0, 2, 1, 1); set_in(3, 2, 0, 1);
    step("ar after", 5'b00001);

    // parallel non-conflicting traffic, then an out-of-range route
    do_reset();
    @(negedge clk); clear_in();
    for (int i = 0; i < N; i++) set_in(i, (i + 1) % N, 1, 1);
    step("par", 5'b11111);
    @(negedge clk); clear_in();
    for (int i = 0; i < N; i++) set_in(i, (i + 1) % N, 1, 1);
    route_sel[2:0] = 3'd7;
    step("par bad route", 5'b11110);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
